cfg_chain_loader: RTL and testbench

//  - Host-side sequencer for the fabric serial config chain. Takes 32-bit words over a

---
 rtl/cfg_chain_loader_if.sv | 21 ++
 rtl/cfg_chain_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_chain_loader_if
//  Purpose  : 32-bit valid/ready word stream feeding the config chain loader.
//             The master (bootstrap/SoC side) drives word_in and word_valid.
//             The slave (loader) returns word_ready.
//             A word transfers on a cycle where word_valid & word_ready.
//  Signals  : word_in    [31:0]  header or payload word
//             word_valid         word_in valid
//             word_ready         slave accepts word_in this cycle
//  Revision : 1.0  initial release
// ============================================================================
interface cfg_chain_loader_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface
`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_chain_loader
//  Purpose  : Host-side sequencer for the fabric serial config chain.
//             It takes a header word and then ceil(LEN/32) payload words.
//             It emits a start pulse, then the ID bits MSB first, then LEN
//             payload bits LSB first, one bit per cycle.
//  Ports    : clk              global clock
//             crst_n           asynchronous active-low config reset
//             word_if          slave side of the word stream
//                              (word_in / word_valid / word_ready)
//             cfg_in_start     one-cycle start pulse to the chain head
//             cfg_bit_in       serial config bit
//             cfg_bit_in_valid qualifier for cfg_bit_in
//             busy             high from header accept until done
//             done             one-cycle pulse after the last payload bit
//             err              one-cycle pulse on a header with LEN == 0
//  Options  : CFG_CHAIN_LOADER_BITCNT_EN adds two outputs:
//             bits_total  saturating count of payload bits driven since reset
//             last_id     ID of the most recent accepted header
//  Revision : 1.0  initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int ID_WIDTH  = 3,
    parameter int LEN_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 crst_n,
    cfg_chain_loader_if.slave         word_if,
    output logic                      cfg_in_start,
    output logic                      cfg_bit_in,
    output logic                      cfg_bit_in_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef CFG_CHAIN_LOADER_BITCNT_EN
    ,
    output logic [31:0]               bits_total,
    output logic [ID_WIDTH-1:0]       last_id
`endif
);
    localparam int C_ID_CW = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
    localparam int C_WC_W  = LEN_WIDTH - 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ID    = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_start;
    logic                  r_bit;
    logic                  r_bit_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_ready;
    logic [ID_WIDTH-1:0]   r_id_sh;
    logic [C_ID_CW-1:0]    r_id_left;     // ID bits still to emit after the current one
    logic [31:0]           r_sh;          // active shift register, LSB leaves first
    logic [5:0]            r_sh_cnt;      // unsent bits in r_sh (0..32)
    logic [31:0]           r_pf;          // prefetch register
    logic                  r_pf_full;
    logic                  r_fetch_pend;  // payload words still to be fetched
    logic [C_WC_W-1:0]     r_words_left;  // words to fetch after the next one
    logic [LEN_WIDTH-1:0]  r_bit_cnt;     // payload bits not yet emitted

    logic                  w_accept;
    logic                  w_hdr_acc;
    logic                  w_pay_acc;
    logic [LEN_WIDTH-1:0]  w_hdr_len;
    logic                  w_sh_has;
    logic                  w_pay_slot;
    logic                  w_emit;
    logic                  w_emit_bit;
    logic                  w_pf_full_nxt;
    logic                  w_fetch_nxt;
    logic                  w_ready_run;

    assign w_accept   = word_if.word_valid & r_ready;
    assign w_hdr_acc  = w_accept & (r_state == S_IDLE);
    assign w_pay_acc  = w_accept & (r_state != S_IDLE);
    assign w_hdr_len  = LEN_WIDTH'(word_if.word_in[31:16]);
    assign w_sh_has   = (r_sh_cnt != 6'd0);

    // A payload bit may be emitted on the edge ending the last ID bit, and on
    // every DATA edge while bits remain. With both buffers empty this edge
    // produces a bubble and the bit counter holds.
    assign w_pay_slot = ((r_state == S_ID) && (r_id_left == '0)) ||
                        ((r_state == S_DATA) && (r_bit_cnt != '0));
    assign w_emit     = w_pay_slot & (w_sh_has | r_pf_full);
    // An empty shift register reloads straight from prefetch, so no bubble.
    assign w_emit_bit = w_sh_has ? r_sh[0] : r_pf[0];

    assign w_pf_full_nxt = (r_pf_full & ~(w_emit & ~w_sh_has)) | w_pay_acc;
    assign w_fetch_nxt   = w_pay_acc ? (r_words_left != '0) : r_fetch_pend;
    assign w_ready_run   = ~w_pf_full_nxt & w_fetch_nxt;

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_bit        <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ready      <= 1'b0;
            r_id_sh      <= '0;
            r_id_left    <= '0;
            r_sh         <= '0;
            r_sh_cnt     <= '0;
            r_pf         <= '0;
            r_pf_full    <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_words_left <= '0;
            r_bit_cnt    <= '0;
        end else begin
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bit_valid <= 1'b0;

            // Payload buffering
            if (w_emit) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
                if (w_sh_has) begin
                    r_sh     <= r_sh >> 1;
                    r_sh_cnt <= r_sh_cnt - 1'b1;
                end else begin
                    r_sh     <= r_pf >> 1;
                    r_sh_cnt <= 6'd31;
                end
            end
            r_pf_full <= w_pf_full_nxt;
            if (w_pay_acc) begin
                r_pf         <= word_if.word_in;
                r_fetch_pend <= (r_words_left != '0);
                if (r_words_left != '0)
                    r_words_left <= r_words_left - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_hdr_acc) begin
                        if (w_hdr_len == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state      <= S_START;
                            r_start      <= 1'b1;
                            r_busy       <= 1'b1;
                            r_id_sh      <= word_if.word_in[ID_WIDTH-1:0];
                            r_bit_cnt    <= w_hdr_len;
                            r_words_left <= C_WC_W'((w_hdr_len - 1'b1) >> 5);
                            r_fetch_pend <= 1'b1;
                            r_sh_cnt     <= '0;
                            r_pf_full    <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    r_state     <= S_ID;
                    r_bit       <= r_id_sh[ID_WIDTH-1];
                    r_bit_valid <= 1'b1;
                    r_id_sh     <= r_id_sh << 1;
                    r_id_left   <= C_ID_CW'(ID_WIDTH - 1);
                    r_ready     <= w_ready_run;
                end
                S_ID: begin
                    r_ready <= w_ready_run;
                    if (r_id_left != '0) begin
                        r_bit       <= r_id_sh[ID_WIDTH-1];
                        r_bit_valid <= 1'b1;
                        r_id_sh     <= r_id_sh << 1;
                        r_id_left   <= r_id_left - 1'b1;
                    end else begin
                        r_state     <= S_DATA;
                        r_bit       <= w_emit_bit;
                        r_bit_valid <= w_emit;
                    end
                end
                S_DATA: begin
                    if (r_bit_cnt != '0) begin
                        r_bit       <= w_emit_bit;
                        r_bit_valid <= w_emit;
                        r_ready     <= w_ready_run;
                    end else begin
                        // Last payload bit is on the wire this cycle
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign word_if.word_ready = r_ready;
    assign cfg_in_start       = r_start;
    assign cfg_bit_in         = r_bit;
    assign cfg_bit_in_valid   = r_bit_valid;
    assign busy               = r_busy;
    assign done               = r_done;
    assign err                = r_err;

`ifdef CFG_CHAIN_LOADER_BITCNT_EN
    logic [31:0]         r_bits_total;
    logic [ID_WIDTH-1:0] r_last_id;

    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            r_bits_total <= '0;
            r_last_id    <= '0;
        end else begin
            if (w_emit && (r_bits_total != 32'hFFFF_FFFF))
                r_bits_total <= r_bits_total + 1'b1;
            if (w_hdr_acc && (w_hdr_len != '0))
                r_last_id <= word_if.word_in[ID_WIDTH-1:0];
        end
    end

    assign bits_total = r_bits_total;
    assign last_id    = r_last_id;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_chain_loader
//  Purpose  : Directed self-checking bench for cfg_chain_loader. Expected
//             serial bits (ID then payload) are queued as words are driven.
//             A negedge monitor pops the queue and compares each valid bit.
//             It also records the timing of start, done and err pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cfg_chain_loader;
    localparam int ID_W = 3;

    logic clk = 1'b0;
    logic crst_n = 1'b0;
    logic cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err;
`ifdef CFG_CHAIN_LOADER_BITCNT_EN
    logic [31:0]     bits_total;
    logic [ID_W-1:0] last_id;
`endif

    cfg_chain_loader_if bus();

    cfg_chain_loader #(.ID_WIDTH(ID_W), .LEN_WIDTH(16)) dut (
        .clk              (clk),
        .crst_n           (crst_n),
        .word_if          (bus),
        .cfg_in_start     (cfg_in_start),
        .cfg_bit_in       (cfg_bit_in),
        .cfg_bit_in_valid (cfg_bit_in_valid),
        .busy             (busy),
        .done             (done),
        .err              (err)
`ifdef CFG_CHAIN_LOADER_BITCNT_EN
        ,
        .bits_total       (bits_total),
        .last_id          (last_id)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    int   rem_bits;

    int start_cnt, start_cyc, done_cnt, done_cyc, err_cnt, err_cyc;
    int busy_rise, pay_cnt, pay_first, pay_last, vidx;
    logic last_bit, busy_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard compare plus pulse bookkeeping
    always @(negedge clk) begin : mon
        logic e_bit;
        if (cfg_in_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            vidx = 0;
        end
        if (busy === 1'b1 && busy_rise < 0) busy_rise = cyc;
        if (cfg_bit_in_valid === 1'b1) begin
            chk("unexpected_bit", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_bit = exp_q.pop_front();
                chk("serial_bit", {31'd0, cfg_bit_in}, {31'd0, e_bit});
            end
            if (vidx >= ID_W) begin
                pay_cnt++;
                if (pay_cnt == 1) pay_first = cyc;
                pay_last = cyc;
                last_bit = cfg_bit_in;
            end
            vidx++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic clear_stats();
        @(posedge clk);
        #1;
        exp_q.delete();
        start_cnt = 0; start_cyc = -1; done_cnt = 0; done_cyc = -1;
        err_cnt = 0; err_cyc = -1; busy_rise = -1; pay_cnt = 0;
        pay_first = -1; pay_last = -1; vidx = 0; last_bit = 1'bx;
        busy_at_done = 1'bx;
        @(negedge clk);
    endtask

    task automatic exp_hdr(input int len, input logic [ID_W-1:0] id);
        for (int i = ID_W - 1; i >= 0; i--) exp_q.push_back(id[i]);
        rem_bits = len;
    endtask

    task automatic exp_word(input logic [31:0] w);
        int n;
        n = (rem_bits > 32) ? 32 : rem_bits;
        for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
        rem_bits -= n;
    endtask

    // Called on a negedge; returns on the negedge after the transfer cycle
    task automatic send_word(input logic [31:0] w, output int t);
        int n;
        n = 0;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        while (bus.word_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 300), 32'd1);
        t = cyc;
        @(negedge clk);
        bus.word_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout", 32'(n < max), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_pay(input int cnt);
        int n;
        n = 0;
        while (pay_cnt < cnt && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pay_timeout", 32'(n < 300), 32'd1);
    endtask

    function automatic logic [31:0] hdr(input int len, input logic [ID_W-1:0] id);
        return {16'(len), 13'd0, id};
    endfunction

    task automatic run_stream(input int len, input logic [ID_W-1:0] id, output int t);
        int tw;
        logic [31:0] w;
        exp_hdr(len, id);
        send_word(hdr(len, id), t);
        for (int k = 0; k < (len + 31) / 32; k++) begin
            w = $urandom;
            exp_word(w);
            send_word(w, tw);
        end
    endtask

    initial begin : watchdog
        #500000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        int t, tw;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        rem_bits       = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {25'd0, cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err, bus.word_ready},
            32'd0);
        crst_n = 1'b1;
        chk("ready_at_release", {31'd0, bus.word_ready}, 32'd0);
        @(negedge clk);
        chk("ready_first_idle", {31'd0, bus.word_ready}, 32'd1);

        // LEN=133, ID=101, back-to-back payload
        clear_stats();
        run_stream(133, 3'b101, t);
        wait_done(400);
        chk("l133_start_cyc", start_cyc, t + 1);
        chk("l133_start_cnt", start_cnt, 1);
        chk("l133_busy_rise", busy_rise, t + 1);
        chk("l133_first_pay", pay_first, t + 5);
        chk("l133_pay_cnt", pay_cnt, 133);
        chk("l133_bubbles", pay_last - pay_first + 1 - pay_cnt, 0);
        chk("l133_done_cyc", done_cyc, t + 138);
        chk("l133_done_cnt", done_cnt, 1);
        chk("l133_busy_at_done", {31'd0, busy_at_done}, 32'd0);
        chk("l133_sb_empty", exp_q.size(), 0);

        // LEN=0 header is rejected
        clear_stats();
        send_word(hdr(0, 3'b111), t);
        chk("l0_err_pulse", {31'd0, err}, 32'd1);
        chk("l0_ready", {31'd0, bus.word_ready}, 32'd1);
        chk("l0_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("l0_err_cyc", err_cyc, t + 1);
        chk("l0_err_cnt", err_cnt, 1);
        chk("l0_no_start", start_cnt, 0);
        chk("l0_ready_after", {31'd0, bus.word_ready}, 32'd1);

        // LEN=40, second word withheld after the first drains: 10 bubbles
        clear_stats();
        exp_hdr(40, 3'b010);
        send_word(hdr(40, 3'b010), t);
        begin
            logic [31:0] w1, w2;
            w1 = $urandom;
            w2 = $urandom;
            exp_word(w1);
            send_word(w1, tw);
            wait_pay(32);
            repeat (9) @(negedge clk);
            exp_word(w2);
            send_word(w2, tw);
        end
        wait_done(200);
        chk("l40_pay_cnt", pay_cnt, 40);
        chk("l40_bubbles", pay_last - pay_first + 1 - pay_cnt, 10);
        chk("l40_done_cyc", done_cyc, pay_last + 1);
        chk("l40_sb_empty", exp_q.size(), 0);

        // LEN=33: only bit 0 of the second word is driven
        clear_stats();
        exp_hdr(33, 3'b001);
        send_word(hdr(33, 3'b001), t);
        exp_word(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, tw);
        exp_word(32'hFFFF_FFFE);
        send_word(32'hFFFF_FFFE, tw);
        wait_done(200);
        chk("l33_pay_cnt", pay_cnt, 33);
        chk("l33_last_bit", {31'd0, last_bit}, 32'd0);
        chk("l33_done_cyc", done_cyc, t + 38);

        // LEN=64, reset at payload bit 20
        clear_stats();
        run_stream(64, 3'b011, t);
        wait_pay(20);
        crst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            {25'd0, cfg_in_start, cfg_bit_in, cfg_bit_in_valid, busy, done, err, bus.word_ready},
            32'd0);
        exp_q.delete();
        @(negedge clk);
        crst_n = 1'b1;
`ifdef CFG_CHAIN_LOADER_BITCNT_EN
        chk("midrst_bits_total", bits_total, 32'd0);
`endif
        repeat (70) @(negedge clk);
        chk("midrst_no_more_bits", pay_cnt, 20);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_ready", {31'd0, bus.word_ready}, 32'd1);

        // Next word is a header: LEN=10 then LEN=7
        clear_stats();
        run_stream(10, 3'b010, t);
        wait_done(100);
        chk("l10_start_cyc", start_cyc, t + 1);
        chk("l10_pay_cnt", pay_cnt, 10);
        chk("l10_done_cyc", done_cyc, t + 15);
        clear_stats();
        run_stream(7, 3'b110, t);
        wait_done(100);
        chk("l7_pay_cnt", pay_cnt, 7);
        chk("l7_done_cyc", done_cyc, t + 12);
        chk("l7_sb_empty", exp_q.size(), 0);
`ifdef CFG_CHAIN_LOADER_BITCNT_EN
        chk("bits_total_17", bits_total, 32'd17);
        chk("last_id", {29'd0, last_id}, {29'd0, 3'b110});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
